// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter between the WB stage and a buffered multi-cycle unit
module regfile_wb_arbiter #(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {PIPE_PRI, FORCE} state_t;

    state_t           state;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_killed;
    logic [4:0]       ent_rd   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [2:0]       age;

    logic          buf_nonempty;
    logic          head_killed;
    logic          head_live;
    logic          grant_pipe;
    logic          grant_head;
    logic          pop;
    logic          push;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] tail_nxt;

    assign buf_nonempty = (count != '0);
    assign head_killed  = buf_nonempty && ent_killed[head];
    assign head_live    = buf_nonempty && !ent_killed[head];
    assign grant_pipe   = (state == PIPE_PRI) && pipe_valid;
    assign grant_head   = head_live && ((state == FORCE) || !pipe_valid);
    // A killed head drains on its own, whoever owns the write port this cycle.
    assign pop          = head_killed || grant_head;
    assign mdu_ready    = (count < CW'(DEPTH));
    // Results to x0 are acknowledged but never take a slot.
    assign push         = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign pipe_stall   = (state == FORCE);
    assign head_nxt     = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
    assign tail_nxt     = (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PIPE_PRI;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            age        <= '0;
            ent_valid  <= '0;
            ent_killed <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_data    <= '0;
        end else begin
            case (state)
                PIPE_PRI: if (buf_nonempty && (age == 3'(AGE_LIMIT - 1)) && !pop) state <= FORCE;
                FORCE:    state <= PIPE_PRI;
                default:  state <= PIPE_PRI;
            endcase

            age <= (!buf_nonempty || pop) ? 3'd0 : age + 3'd1;

            if (grant_pipe) begin
                rf_we   <= (pipe_rd != 5'd0);
                rf_rd   <= pipe_rd;
                rf_data <= pipe_data;
            end else if (grant_head) begin
                rf_we   <= 1'b1;
                rf_rd   <= ent_rd[head];
                rf_data <= ent_data[head];
            end else begin
                rf_we   <= 1'b0;
            end

            // The WB instruction is younger, so its write supersedes any buffered result to the same rd.
            if (grant_pipe && (pipe_rd != 5'd0)) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_valid[i] && (ent_rd[i] == pipe_rd)) ent_killed[i] <= 1'b1;
                end
            end

            if (pop) begin
                ent_valid[head]  <= 1'b0;
                ent_killed[head] <= 1'b0;
                head             <= head_nxt;
            end

            if (push) begin
                ent_valid[tail]  <= 1'b1;
                ent_killed[tail] <= 1'b0;
                ent_rd[tail]     <= mdu_rd;
                ent_data[tail]   <= mdu_data;
                tail             <= tail_nxt;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH     = 2;
    localparam int AGE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t m_q[$];
    int   m_age;
    bit   m_force;
    int   vectors;
    int   miscompares;
    bit   last_stall;
    bit   last_ready;
    logic obs_stall;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_age   = 0;
        m_force = 1'b0;
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        mdu_valid  = mv; mdu_rd  = mrd; mdu_data  = md;
    endtask

    // One clock of the reference model: decide the grant from the current inputs, check, advance.
    task automatic step();
        bit          ready_e, pop, wr, nf;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        ent_t        e;
        ready_e = (m_q.size() < DEPTH);
        obs_stall = pipe_stall;
        chk("mdu_ready", mdu_ready, ready_e);
        chk("pipe_stall", pipe_stall, m_force);
        last_stall = m_force;
        last_ready = ready_e;
        wr = 0; pop = 0; wrd = 0; wdata = 0;
        if (m_q.size() > 0 && m_q[0].killed) pop = 1;
        if (!m_force && pipe_valid) begin
            wr = (pipe_rd != 0); wrd = pipe_rd; wdata = pipe_data;
            if (pipe_rd != 0)
                foreach (m_q[i]) if (m_q[i].rd == pipe_rd) m_q[i].killed = 1;
        end else if (m_q.size() > 0 && !pop) begin
            wr = 1; wrd = m_q[0].rd; wdata = m_q[0].data; pop = 1;
        end
        nf = !m_force && m_q.size() > 0 && m_age == AGE_LIMIT - 1 && !pop;
        m_age = (m_q.size() == 0 || pop) ? 0 : m_age + 1;
        m_force = nf;
        if (pop) void'(m_q.pop_front());
        if (mdu_valid && ready_e && mdu_rd != 0) begin
            e.rd = mdu_rd; e.data = mdu_data; e.killed = 0;
            m_q.push_back(e);
        end
        @(posedge clk); #1;
        chk("rf_we", rf_we, wr);
        if (wr) begin
            chk("rf_rd", rf_rd, wrd);
            chk("rf_data", rf_data, wdata);
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        int stall_cnt, stall_at;
        logic [4:0] force_rd;
        logic force_we;
        vectors = 0; miscompares = 0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #11;
        chk("rst_mdu_ready", mdu_ready, 1);
        chk("rst_pipe_stall", pipe_stall, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_data, 0);
        @(posedge clk); #1;
        chk("rst_hold_rf_we", rf_we, 0);
        #2 rst = 1'b1;

        // Plain WB write lands one cycle later.
        drive(1, 5, 32'h12345678, 0, 0, 0); step();
        chk("r031_we", rf_we, 1); chk("r031_rd", rf_rd, 5); chk("r031_data", rf_data, 32'h12345678);
        idle(1);

        // MDU result with idle pipe: written at push+2.
        drive(0, 0, 0, 1, 7, 32'hA); step();
        chk("r032_we_p1", rf_we, 0);
        idle(1);
        chk("r032_we_p2", rf_we, 1); chk("r032_rd", rf_rd, 7); chk("r032_data", rf_data, 32'hA);
        idle(2);

        // Continuous pipe traffic starves the head until the age limit forces one stall.
        drive(1, 3, 32'h33, 1, 11, 32'hB); step();
        drive(1, 3, 32'h33, 0, 0, 0);
        stall_cnt = 0; stall_at = 0; force_rd = 0; force_we = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (obs_stall === 1'b1) begin
                stall_cnt++; stall_at = k; force_rd = rf_rd; force_we = rf_we;
            end
        end
        chk("r033_stall_cycles", stall_cnt, 1);
        chk("r033_stall_at", stall_at, AGE_LIMIT + 1);
        chk("r033_force_we", force_we, 1);
        chk("r033_force_rd", force_rd, 11);
        idle(3);

        // Full buffer back-pressures the unit until a pop frees a slot.
        drive(1, 1, 32'h100, 1, 12, 32'hC); step();
        drive(1, 1, 32'h101, 1, 13, 32'hD); step();
        drive(1, 1, 32'h102, 1, 14, 32'hE);
        chk("r034_full_ready", mdu_ready, 0);
        step();
        drive(0, 0, 0, 1, 14, 32'hE);
        chk("r034_still_full", mdu_ready, 0);
        step();
        chk("r034_pop12", rf_rd, 12);
        chk("r034_ready_after_pop", mdu_ready, 1);
        step();
        chk("r034_pop13", rf_rd, 13);
        idle(4);

        // Younger WB write to the same rd kills the buffered result.
        drive(1, 1, 32'h1, 1, 9, 32'h99); step();
        drive(1, 9, 32'hBEEF, 0, 0, 0); step();
        chk("r035_pipe_rd", rf_rd, 9); chk("r035_pipe_data", rf_data, 32'hBEEF);
        idle(1);
        chk("r035_killed_pop_we", rf_we, 0);
        idle(1);
        chk("r035_after_we", rf_we, 0);
        chk("r035_empty_ready", mdu_ready, 1);
        idle(2);

        // Asynchronous reset with two results buffered.
        drive(1, 1, 32'h1, 1, 20, 32'h20); step();
        drive(1, 2, 32'h2, 1, 21, 32'h21); step();
        drive(1, 3, 32'h3, 0, 0, 0); step();
        chk("r036_pre_we", rf_we, 1);
        #2 rst = 1'b0;
        #1;
        chk("r036_async_we", rf_we, 0);
        chk("r036_async_rd", rf_rd, 0);
        chk("r036_async_data", rf_data, 0);
        chk("r036_async_ready", mdu_ready, 1);
        chk("r036_async_stall", pipe_stall, 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("r036_in_reset_we", rf_we, 0);
        #2 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("r036_post_we", rf_we, 0);
        end

        // Randomised traffic; requests are held while stalled / not accepted.
        for (int n = 0; n < 500; n++) begin
            if (!(pipe_valid && last_stall)) begin
                pipe_valid = ($urandom_range(0, 9) < 5);
                pipe_rd    = 5'($urandom_range(0, 7));
                pipe_data  = $urandom;
            end
            if (!(mdu_valid && !last_ready)) begin
                mdu_valid = ($urandom_range(0, 9) < 4);
                mdu_rd    = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            step();
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
